// File: rtl/ledpwm_fta64_if.sv
// FTA 64-bit command bus types and the slave-select/request/response bundle
// used by the LED PWM port.
package fta_bus_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_ERC     = 3'b111;

    typedef struct packed {
        logic [3:0]  cid;
        logic [7:0]  tid;
        logic        we;
        logic [2:0]  cti;
        logic [31:0] padr;
        logic [63:0] dat;
    } fta_cmd_request64_t;

    typedef struct packed {
        logic [3:0]  cid;
        logic [7:0]  tid;
        logic [3:0]  pri;
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] adr;
        logic [63:0] dat;
    } fta_cmd_response64_t;

endpackage

interface ledpwm_fta64_if;
    import fta_bus_pkg::*;

    logic                cs;
    fta_cmd_request64_t  req;
    fta_cmd_response64_t resp;

    modport master (output cs, output req, input  resp);
    modport slave  (input  cs, input  req, output resp);
endinterface

// File: rtl/ledpwm_fta64.sv
// Up to 16 LED outputs, each static, PWM-dimmed, blinking or both, with all
// control registers readable over the 64-bit FTA bus.
module ledpwm_fta64
    import fta_bus_pkg::*;
#(
    parameter int          NLED      = 8,
    parameter int          PRESCALE  = 64,
    parameter logic [15:0] BLINK_RST = 16'd256
) (
    input  logic            clk,
    input  logic            rst,
    ledpwm_fta64_if.slave   bus,
    output logic [NLED-1:0] led
);

    // A prescale of 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        REG_OUT    = 3'd0,
        REG_MODE   = 3'd1,
        REG_DUTY0  = 3'd2,
        REG_DUTY1  = 3'd3,
        REG_BLINK  = 3'd4,
        REG_STATUS = 3'd5,
        REG_RSV6   = 3'd6,
        REG_RSV7   = 3'd7
    } reg_sel_t;

    reg_sel_t        sel;
    logic            wr;
    logic            rd;
    logic            tick;
    logic            frame;
    logic [PW-1:0]   pre_cnt;
    logic [7:0]      pwm_cnt;
    logic [15:0]     blink_cnt;
    logic            phase;
    logic [NLED-1:0] out_reg;
    logic [2*NLED-1:0] mode;
    logic [7:0]      duty [NLED];
    logic [15:0]     blink;
    logic [NLED-1:0] pwm_on;
    logic [NLED-1:0] lit;
    logic [63:0]     rdata;

    assign sel   = reg_sel_t'(bus.req.padr[5:3]);
    assign wr    = bus.cs && bus.req.we;
    assign rd    = bus.cs && !bus.req.we;
    assign tick  = (pre_cnt == PRE_MAX);
    assign frame = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= 8'd0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // A BLINK write restarts the half-period even if a frame lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= 16'd0;
            phase     <= 1'b1;
        end else if (wr && sel == REG_BLINK) begin
            blink_cnt <= 16'd0;
            phase     <= 1'b1;
        end else if (blink == 16'd0) begin
            blink_cnt <= 16'd0;
            phase     <= 1'b1;
        end else if (frame) begin
            if (blink_cnt == blink - 16'd1) begin
                blink_cnt <= 16'd0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= '0;
            mode    <= '0;
            blink   <= BLINK_RST;
            for (int i = 0; i < NLED; i++)
                duty[i] <= 8'd0;
        end else if (wr) begin
            case (sel)
                REG_OUT:   out_reg <= bus.req.dat[NLED-1:0];
                REG_MODE:  mode    <= bus.req.dat[2*NLED-1:0];
                REG_DUTY0: for (int i = 0; i < NLED; i++)
                               if (i < 8) duty[i] <= bus.req.dat[8*(i%8) +: 8];
                REG_DUTY1: for (int i = 0; i < NLED; i++)
                               if (i >= 8) duty[i] <= bus.req.dat[8*(i%8) +: 8];
                REG_BLINK: blink   <= bus.req.dat[15:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_OUT:    rdata[NLED-1:0]   = out_reg;
            REG_MODE:   rdata[2*NLED-1:0] = mode;
            REG_DUTY0:  for (int i = 0; i < NLED; i++)
                            if (i < 8) rdata[8*(i%8) +: 8] = duty[i];
            REG_DUTY1:  for (int i = 0; i < NLED; i++)
                            if (i >= 8) rdata[8*(i%8) +: 8] = duty[i];
            REG_BLINK:  rdata[15:0] = blink;
            REG_STATUS: begin
                rdata[7:0]   = pwm_cnt;
                rdata[8]     = phase;
                rdata[31:16] = blink_cnt;
            end
            default:    ;
        endcase
    end

    // Mode bit 0 gates with the PWM comparator, mode bit 1 with the blink phase.
    always_comb begin
        pwm_on = '0;
        lit    = '0;
        for (int i = 0; i < NLED; i++) begin
            pwm_on[i] = (pwm_cnt < duty[i]);
            lit[i]    = out_reg[i] & (~mode[2*i] | pwm_on[i]) & (~mode[2*i+1] | phase);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            led <= '0;
        else
            led <= lit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resp <= '0;
        end else begin
            bus.resp.cid <= bus.req.cid;
            bus.resp.tid <= bus.req.tid;
            bus.resp.adr <= bus.req.padr;
            bus.resp.pri <= 4'd7;
            bus.resp.err <= 1'b0;
            bus.resp.rty <= 1'b0;
            bus.resp.ack <= bus.cs && (!bus.req.we || bus.req.cti == CTI_ERC);
            bus.resp.dat <= rd ? rdata : 64'd0;
        end
    end

endmodule

// File: tb/tb_ledpwm_fta64.sv
// Scoreboard bench for ledpwm_fta64: bus responses are checked against a queue
// of expectations pushed as each request is driven; LED timing is counted directly.
module tb_ledpwm_fta64;
    import fta_bus_pkg::*;

    localparam int NLED = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NLED-1:0] led;

    ledpwm_fta64_if bus();

    ledpwm_fta64 #(
        .NLED      (NLED),
        .PRESCALE  (1),
        .BLINK_RST (16'd256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .led (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        ack;
        logic        chk_dat;
        logic [63:0] dat;
        logic [7:0]  tid;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         check_count = 0;
    int         pass_count  = 0;
    logic [7:0] tid_next    = 8'd0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Drives one request for a single cycle and records what the response must be.
    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] cti,
                                 input logic [2:0] regsel, input logic [63:0] wdata,
                                 input logic chk_dat, input logic [63:0] exp_dat);
        exp_t e;
        @(negedge clk);
        bus.cs       = 1'b1;
        bus.req.we   = we;
        bus.req.cti  = cti;
        bus.req.cid  = 4'h3;
        bus.req.tid  = tid_next;
        bus.req.padr = {26'd0, regsel, 3'b000};
        bus.req.dat  = wdata;
        e.tag     = tag;
        e.ack     = !we || (cti == CTI_ERC);
        e.chk_dat = chk_dat;
        e.dat     = we ? 64'd0 : exp_dat;
        e.tid     = tid_next;
        sb_q.push_back(e);
        tid_next++;
    endtask

    task automatic writeReg(input string tag, input logic [2:0] regsel, input logic [63:0] data,
                            input logic [2:0] cti = CTI_ERC);
        applyStimulus(tag, 1'b1, cti, regsel, data, 1'b1, 64'd0);
    endtask

    task automatic readReg(input string tag, input logic [2:0] regsel, input logic [63:0] exp_dat);
        applyStimulus(tag, 1'b0, CTI_CLASSIC, regsel, 64'd0, 1'b1, exp_dat);
    endtask

    task automatic busIdle();
        @(negedge clk);
        bus.cs     = 1'b0;
        bus.req.we = 1'b0;
    endtask

    // Six back-to-back reads issued right after reset release; pwm_cnt has advanced by 6.
    task automatic readResetRegs(input string pfx);
        readReg({pfx, ".out"},    3'd0, 64'd0);
        readReg({pfx, ".mode"},   3'd1, 64'd0);
        readReg({pfx, ".duty0"},  3'd2, 64'd0);
        readReg({pfx, ".duty1"},  3'd3, 64'd0);
        readReg({pfx, ".blink"},  3'd4, 64'h100);
        readReg({pfx, ".status"}, 3'd5, 64'h106);
        busIdle();
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput({mon_e.tag, ".ack"}, 64'(bus.resp.ack), 64'(mon_e.ack));
            checkOutput({mon_e.tag, ".tid"}, 64'(bus.resp.tid), 64'(mon_e.tid));
            if (mon_e.chk_dat)
                checkOutput({mon_e.tag, ".dat"}, bus.resp.dat, mon_e.dat);
        end else if (bus.resp.ack) begin
            checkOutput("idle.ack", 64'(bus.resp.ack), 64'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int hi0, hi8, n, k, run_hi, run_lo, max_hi, max_lo;
    logic [7:0] p;

    initial begin
        rst     = 1'b1;
        bus.cs  = 1'b0;
        bus.req = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.led", 64'(led), 64'd0);
        checkOutput("reset.resp_ctl", 64'({bus.resp.pri, bus.resp.ack, bus.resp.err,
                    bus.resp.rty, bus.resp.cid, bus.resp.tid}), 64'd0);
        checkOutput("reset.resp_dat", bus.resp.dat, 64'd0);
        rst = 1'b0;
        readResetRegs("init");
        readReg("rsv6.rd0", 3'd6, 64'd0);
        busIdle();

        // Static output writes: ERC acks, classic does not, both update the LEDs.
        writeReg("out.wr_erc", 3'd0, 64'hDEAD_BEEF_0000_12A5, CTI_ERC);
        busIdle();
        checkOutput("out.led_latency", 64'(led), 64'd0);
        @(negedge clk);
        checkOutput("out.led_erc", 64'(led), 64'h12A5);
        writeReg("out.wr_classic", 3'd0, 64'h3C, CTI_CLASSIC);
        busIdle();
        @(negedge clk);
        checkOutput("out.led_classic", 64'(led), 64'h003C);
        readReg("out.rd", 3'd0, 64'h3C);
        writeReg("rsv6.wr", 3'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        readReg("rsv6.rd1", 3'd6, 64'd0);
        busIdle();

        // PWM dimming on LED0 (duty 0x40) and LED8 (duty 0xFF).
        writeReg("pwm.mode", 3'd1, 64'h0001_0001);
        writeReg("pwm.duty0", 3'd2, 64'h1122_3344_5566_7740);
        writeReg("pwm.duty1", 3'd3, 64'h0000_0000_0000_00FF);
        writeReg("pwm.out", 3'd0, 64'h0101);
        readReg("pwm.duty0_rd", 3'd2, 64'h1122_3344_5566_7740);
        readReg("pwm.duty1_rd", 3'd3, 64'h0000_0000_0000_00FF);
        readReg("pwm.mode_rd", 3'd1, 64'h0001_0001);
        busIdle();
        repeat (2) @(negedge clk);
        hi0 = 0; hi8 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi0 += int'(led[0]);
            hi8 += int'(led[8]);
        end
        checkOutput("pwm.duty40_high", 64'(hi0), 64'd64);
        checkOutput("pwm.dutyff_high", 64'(hi8), 64'd255);
        writeReg("pwm.duty0_zero", 3'd2, 64'd0);
        busIdle();
        repeat (2) @(negedge clk);
        hi0 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi0 += int'(led[0]);
        end
        checkOutput("pwm.duty0_high", 64'(hi0), 64'd0);

        // Blink with a two-frame half-period: 512 cycles per phase at prescale 1.
        writeReg("blink.mode", 3'd1, 64'h2);
        writeReg("blink.out", 3'd0, 64'h1);
        writeReg("blink.wr", 3'd4, 64'd2);
        readReg("blink.rd", 3'd4, 64'd2);
        busIdle();
        checkOutput("resp.pri", 64'(bus.resp.pri), 64'd7);
        checkOutput("resp.adr", 64'(bus.resp.adr), 64'h20);
        n = 0;
        while (led[0] !== 1'b0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("blink.first_half", 64'(n <= 520), 64'd1);
        hi0 = 0; run_hi = 0; run_lo = 0; max_hi = 0; max_lo = 0;
        for (int i = 0; i < 2048; i++) begin
            if (led[0]) begin
                hi0++; run_hi++; run_lo = 0;
            end else begin
                run_lo++; run_hi = 0;
            end
            if (run_hi > max_hi) max_hi = run_hi;
            if (run_lo > max_lo) max_lo = run_lo;
            @(negedge clk);
        end
        checkOutput("blink.high_total", 64'(hi0), 64'd1024);
        checkOutput("blink.high_run", 64'(max_hi), 64'd512);
        checkOutput("blink.low_run", 64'(max_lo), 64'd512);
        writeReg("blink.zero", 3'd4, 64'd0);
        busIdle();
        repeat (2) @(negedge clk);
        hi0 = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            hi0 += int'(led[0]);
        end
        checkOutput("blink.zero_held", 64'(hi0), 64'd600);

        // BLINK write landing on the same edge as a frame must win.
        writeReg("coinc.pre", 3'd4, 64'd3);
        applyStimulus("coinc.probe", 1'b0, CTI_CLASSIC, 3'd5, 64'd0, 1'b0, 64'd0);
        @(posedge clk);
        #1;
        p = bus.resp.dat[7:0];
        k = 255 - int'(p);
        if (k < 2) k += 256;
        busIdle();
        repeat (k - 2) @(negedge clk);
        writeReg("coinc.wr", 3'd4, 64'd3);
        readReg("coinc.status", 3'd5, 64'h100);
        busIdle();

        // Asynchronous reset with LEDs lit and an ack on the bus.
        writeReg("rst.mode", 3'd1, 64'd0);
        writeReg("rst.out", 3'd0, 64'hFFFF);
        busIdle();
        repeat (2) @(negedge clk);
        checkOutput("rst.led_lit", 64'(led), 64'hFFFF);
        readReg("rst.pre_rd", 3'd0, 64'hFFFF);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst.led", 64'(led), 64'd0);
        checkOutput("rst.ack", 64'(bus.resp.ack), 64'd0);
        busIdle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        readResetRegs("post");
        checkOutput("post.led", 64'(led), 64'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
